// File: rtl/dcache_tag_arbiter.sv
// L1 data-cache SRAM arbiter: fixed-priority miss port plus round-robin controllers,
// one-cycle tag compare, invalid-first / LFSR victim choice and a set-by-set invalidate sweep.
module dcache_tag_arbiter #(
  parameter int NR_PORTS    = 4,
  parameter int NUM_WAYS    = 8,
  parameter int INDEX_W     = 12,
  parameter int BYTE_OFFSET = 4,
  parameter int TAG_W       = 44,
  parameter int LINE_W      = 128,
  localparam int LW         = TAG_W + LINE_W + 2,
  localparam int BE_W       = (TAG_W + 7) / 8 + (LINE_W + 7) / 8 + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NR_PORTS*NUM_WAYS-1:0] req_i,
  input  logic [NR_PORTS*INDEX_W-1:0]  addr_i,
  input  logic [NR_PORTS-1:0]          we_i,
  input  logic [NR_PORTS*LW-1:0]       wdata_i,
  input  logic [NR_PORTS*BE_W-1:0]     be_i,
  input  logic [NR_PORTS*TAG_W-1:0]    tag_i,
  output logic [NR_PORTS-1:0]          gnt_o,
  output logic [NR_PORTS-1:0]          rvalid_o,
  output logic [NUM_WAYS*LW-1:0]       rdata_o,
  output logic [NUM_WAYS-1:0]          hit_way_o,
  output logic                         multihit_o,
  output logic [NUM_WAYS-1:0]          victim_way_o,
  input  logic                         inval_i,
  output logic                         init_done_o,
  output logic [NUM_WAYS-1:0]          sram_req_o,
  output logic [INDEX_W-1:0]           sram_addr_o,
  output logic                         sram_we_o,
  output logic [LW-1:0]                sram_wdata_o,
  output logic [BE_W-1:0]              sram_be_o,
  input  logic [NUM_WAYS*LW-1:0]       sram_rdata_i
);

  localparam int SET_W  = INDEX_W - BYTE_OFFSET;
  localparam int SETS   = 2 ** SET_W;
  localparam int PORT_W = $clog2(NR_PORTS);
  localparam int WAY_W  = $clog2(NUM_WAYS);

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SET_W-1:0]    r_set;
  logic [SET_W-1:0]    w_set_nxt;
  logic [PORT_W-1:0]   r_rr;
  logic [PORT_W-1:0]   r_id;
  logic                r_rd;
  logic [15:0]         r_lfsr;

  logic [NR_PORTS-1:0] w_port_req;
  logic                w_gnt_any;
  logic [PORT_W-1:0]   w_winner;
  logic [PORT_W-1:0]   w_cand;
  logic [TAG_W-1:0]    w_cmp_tag;
  logic [NUM_WAYS-1:0] w_valid;
  logic                w_inv_found;
  logic                w_lfsr_fb;

  always_comb begin
    w_state_nxt = r_state;
    w_set_nxt   = r_set;
    case (r_state)
      ST_SWEEP: begin
        w_set_nxt = r_set + 1'b1;
        if (r_set == SET_W'(SETS - 1)) w_state_nxt = ST_RUN;
      end
      default: begin
        if (inval_i) begin
          w_state_nxt = ST_SWEEP;
          w_set_nxt   = '0;
        end
      end
    endcase
  end

  genvar gp;
  generate
    for (gp = 0; gp < NR_PORTS; gp++) begin : g_port
      assign w_port_req[gp] = |req_i[gp*NUM_WAYS +: NUM_WAYS];
    end
  endgenerate

  // Controller search starts just after the last granted controller and wraps within 1..NR_PORTS-1.
  always_comb begin
    w_gnt_any = 1'b0;
    w_winner  = '0;
    w_cand    = '0;
    if (r_state == ST_RUN) begin
      if (w_port_req[0]) begin
        w_gnt_any = 1'b1;
      end else begin
        for (int k = 1; k < NR_PORTS; k++) begin
          w_cand = PORT_W'(((int'(r_rr) - 1 + k) % (NR_PORTS - 1)) + 1);
          if (!w_gnt_any && w_port_req[w_cand]) begin
            w_gnt_any = 1'b1;
            w_winner  = w_cand;
          end
        end
      end
    end
  end

  assign gnt_o = w_gnt_any ? (NR_PORTS'(1) << w_winner) : '0;

  always_comb begin
    sram_req_o   = '0;
    sram_addr_o  = '0;
    sram_we_o    = 1'b0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (r_state == ST_SWEEP) begin
      sram_req_o  = '1;
      sram_addr_o = {r_set, {BYTE_OFFSET{1'b0}}};
      sram_we_o   = 1'b1;
      sram_be_o   = '1;
    end else if (w_gnt_any) begin
      sram_req_o   = req_i[int'(w_winner)*NUM_WAYS +: NUM_WAYS];
      sram_addr_o  = addr_i[int'(w_winner)*INDEX_W +: INDEX_W];
      sram_we_o    = we_i[w_winner];
      sram_wdata_o = wdata_i[int'(w_winner)*LW +: LW];
      sram_be_o    = be_i[int'(w_winner)*BE_W +: BE_W];
    end
  end

  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_SWEEP;
      r_set   <= '0;
      r_rr    <= PORT_W'(NR_PORTS - 1);
      r_id    <= '0;
      r_rd    <= 1'b0;
      r_lfsr  <= 16'hACE1;
    end else begin
      r_state <= w_state_nxt;
      r_set   <= w_set_nxt;
      r_rd    <= w_gnt_any && !we_i[w_winner];
      r_id    <= w_winner;
      if (w_gnt_any && (w_winner != '0)) r_rr <= w_winner;
      if (r_rd) r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  // Response side: line layout is {tag, data, valid, dirty}.
  assign rvalid_o  = r_rd ? (NR_PORTS'(1) << r_id) : '0;
  assign rdata_o   = sram_rdata_i;
  assign w_cmp_tag = tag_i[int'(r_id)*TAG_W +: TAG_W];

  genvar gw;
  generate
    for (gw = 0; gw < NUM_WAYS; gw++) begin : g_way
      assign w_valid[gw]   = sram_rdata_i[gw*LW + 1];
      assign hit_way_o[gw] = w_valid[gw] &&
                             (sram_rdata_i[gw*LW + LW - 1 -: TAG_W] == w_cmp_tag);
    end
  endgenerate

  assign multihit_o = r_rd && ((hit_way_o & (hit_way_o - NUM_WAYS'(1))) != '0);

  always_comb begin
    victim_way_o = '0;
    w_inv_found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_inv_found && !w_valid[w]) begin
        victim_way_o[w] = 1'b1;
        w_inv_found     = 1'b1;
      end
    end
    if (!w_inv_found) victim_way_o = NUM_WAYS'(1) << r_lfsr[WAY_W-1:0];
  end

  assign init_done_o = (r_state == ST_RUN);

endmodule

// File: tb/tb_dcache_tag_arbiter.sv
// Directed bench for dcache_tag_arbiter: arbitration vector table plus hand-written
// sweep, hit, victim, invalidate and reset sequences against a behavioural SRAM.
module tb_dcache_tag_arbiter;
  localparam int NP  = 4;
  localparam int NW  = 8;
  localparam int IW  = 12;
  localparam int BO  = 4;
  localparam int TW  = 44;
  localparam int LWD = 128;
  localparam int LW  = TW + LWD + 2;
  localparam int BEW = (TW + 7) / 8 + (LWD + 7) / 8 + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*NW-1:0]  req;
  logic [NP*IW-1:0]  addr;
  logic [NP-1:0]     we;
  logic [NP*LW-1:0]  wdata;
  logic [NP*BEW-1:0] be;
  logic [NP*TW-1:0]  tag;
  logic [NP-1:0]     gnt;
  logic [NP-1:0]     rvalid;
  logic [NW*LW-1:0]  rdata;
  logic [NW-1:0]     hit;
  logic              multihit;
  logic [NW-1:0]     victim;
  logic              inval;
  logic              init_done;
  logic [NW-1:0]     s_req;
  logic [IW-1:0]     s_addr;
  logic              s_we;
  logic [LW-1:0]     s_wdata;
  logic [BEW-1:0]    s_be;
  logic [NW*LW-1:0]  s_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [IW-1:0] exp_q[$];

  always #5 clk = ~clk;

  dcache_tag_arbiter #(
    .NR_PORTS(NP), .NUM_WAYS(NW), .INDEX_W(IW), .BYTE_OFFSET(BO), .TAG_W(TW), .LINE_W(LWD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .be_i(be), .tag_i(tag), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .hit_way_o(hit), .multihit_o(multihit), .victim_way_o(victim), .inval_i(inval),
    .init_done_o(init_done), .sram_req_o(s_req), .sram_addr_o(s_addr), .sram_we_o(s_we),
    .sram_wdata_o(s_wdata), .sram_be_o(s_be), .sram_rdata_i(s_rdata)
  );

  // Behavioural single-port SRAM ways with byte-enable masking and 1-cycle read latency.
  logic [LW-1:0] mem [NW][256];

  function automatic logic [LW-1:0] be_mask(input logic [BEW-1:0] b);
    logic [LW-1:0] m;
    m      = '0;
    m[1:0] = {2{b[0]}};
    for (int i = 0; i < LWD; i++) m[2+i] = b[1+i/8];
    for (int i = 0; i < TW; i++) m[2+LWD+i] = b[1+LWD/8+i/8];
    return m;
  endfunction

  always @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (s_req[w]) begin
        if (s_we)
          mem[w][s_addr[IW-1:BO]] <= (mem[w][s_addr[IW-1:BO]] & ~be_mask(s_be)) |
                                     (s_wdata & be_mask(s_be));
        else
          s_rdata[w*LW +: LW] <= mem[w][s_addr[IW-1:BO]];
      end
    end
  end

  function automatic logic [LW-1:0] mk_line(input logic [TW-1:0] t, input logic v);
    return {t, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, v, 1'b0};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
    return (s >> 1) | (16'(b) << 15);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    req   = '0;
    we    = '0;
    inval = 1'b0;
  endtask

  task automatic put(input int p, input logic [NW-1:0] r, input logic [IW-1:0] a,
                     input logic w, input logic [LW-1:0] line);
    req[p*NW +: NW]    = r;
    addr[p*IW +: IW]   = a;
    we[p]              = w;
    wdata[p*LW +: LW]  = line;
    be[p*BEW +: BEW]   = '1;
  endtask

  task automatic set_tag(input int p, input logic [TW-1:0] t);
    tag[p*TW +: TW] = t;
  endtask

  task automatic sb_fill();
    exp_q.delete();
    for (int k = 0; k < 256; k++) exp_q.push_back(IW'(k << BO));
  endtask

  // Caller has already reached the negedge and driven inputs for this cycle.
  task automatic sweep_cycle();
    logic [IW-1:0] ea;
    #1;
    if (exp_q.size() == 0) begin
      chk("sweep_queue_empty", 1'b1, 1'b0);
    end else begin
      ea = exp_q.pop_front();
      chk("sweep_addr", s_addr, ea);
    end
    chk("sweep_ctl", {s_req, s_we, gnt, init_done}, {8'hFF, 1'b1, 4'b0000, 1'b0});
    chk("sweep_data", {(s_wdata == '0), (s_be == '1)}, 2'b11);
  endtask

  task automatic sweep_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = 1'b0;
      sweep_cycle();
    end
  endtask

  task automatic sweep_done();
    @(negedge clk);
    #1;
    chk("init_done_rise", init_done, 1'b1);
  endtask

  typedef struct {
    logic [NP-1:0] preq;
    logic [NP-1:0] exp_gnt;
    logic [NP-1:0] exp_rvalid;
  } vec_t;
  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t limit %0d)", $time, 200000);
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] ea;
    logic [15:0]   model;
    logic [NW-1:0] vbits;

    vecs[0]  = '{4'b1111, 4'b0001, 4'b0000};
    vecs[1]  = '{4'b1111, 4'b0001, 4'b0001};
    vecs[2]  = '{4'b1110, 4'b0010, 4'b0001};
    vecs[3]  = '{4'b1110, 4'b0100, 4'b0010};
    vecs[4]  = '{4'b1110, 4'b1000, 4'b0100};
    vecs[5]  = '{4'b1110, 4'b0010, 4'b1000};
    vecs[6]  = '{4'b1110, 4'b0100, 4'b0010};
    vecs[7]  = '{4'b1111, 4'b0001, 4'b0100};
    vecs[8]  = '{4'b1110, 4'b1000, 4'b0001};
    vecs[9]  = '{4'b1010, 4'b0010, 4'b1000};
    vecs[10] = '{4'b1010, 4'b1000, 4'b0010};
    vecs[11] = '{4'b0100, 4'b0100, 4'b1000};
    vecs[12] = '{4'b0000, 4'b0000, 4'b0100};
    vecs[13] = '{4'b0001, 4'b0001, 4'b0000};

    for (int w = 0; w < NW; w++)
      for (int s = 0; s < 256; s++) mem[w][s] = '1;
    s_rdata = '0;
    rst = 1'b1;
    idle();
    addr = '0; wdata = '0; be = '0; tag = '0;

    // Reset values, then full power-on sweep
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {gnt, rvalid, multihit, init_done}, 10'b0);
    sb_fill();
    sweep_cycles(256);
    sweep_done();
    chk("post_sweep_gnt", gnt, 4'b0000);

    // Read-back after sweep: every way invalid
    @(negedge clk); idle(); put(0, 8'hFF, 12'h340, 1'b0, '0); #1;
    chk("readback_gnt", gnt, 4'b0001);
    @(negedge clk); idle(); set_tag(0, 44'h0); #1;
    for (int w = 0; w < NW; w++) vbits[w] = rdata[w*LW + 1];
    chk("readback_rvalid", rvalid, 4'b0001);
    chk("readback_valid_bits", vbits, 8'h00);
    chk("readback_hit", hit, 8'h00);
    chk("readback_victim", victim, 8'h01);

    // Priority and round-robin table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); idle();
      for (int p = 0; p < NP; p++)
        if (vecs[i].preq[p]) put(p, 8'hFF, IW'((p + 1) * 256), 1'b0, '0);
      #1;
      chk($sformatf("arb_gnt[%0d]", i), gnt, vecs[i].exp_gnt);
      chk($sformatf("arb_rvalid[%0d]", i), rvalid, vecs[i].exp_rvalid);
      if (vecs[i].exp_gnt != '0) begin
        ea = '0;
        for (int p = 0; p < NP; p++) if (vecs[i].exp_gnt[p]) ea = IW'((p + 1) * 256);
        chk($sformatf("arb_addr[%0d]", i), s_addr, ea);
      end
    end
    @(negedge clk); idle(); #1;
    chk("arb_tail_rvalid", rvalid, 4'b0001);

    // Hit detection: way 5 @0x340 tag 0x123
    @(negedge clk); idle(); put(0, 8'h20, 12'h340, 1'b1, mk_line(44'h123, 1'b1)); #1;
    chk("wr_gnt", gnt, 4'b0001);
    chk("wr_sram", {s_req, s_addr, s_we}, {8'h20, 12'h340, 1'b1});
    chk("wr_wdata", s_wdata, mk_line(44'h123, 1'b1));
    @(negedge clk); idle(); put(2, 8'hFF, 12'h340, 1'b0, '0); #1;
    chk("rd2_gnt", gnt, 4'b0100);
    chk("write_no_rvalid", rvalid, 4'b0000);
    @(negedge clk); idle(); set_tag(2, 44'h123); #1;
    chk("hit_rvalid", rvalid, 4'b0100);
    chk("hit_way", hit, 8'h20);
    chk("hit_multihit", multihit, 1'b0);
    chk("hit_victim", victim, 8'h01);
    @(negedge clk); idle(); put(2, 8'hFF, 12'h340, 1'b0, '0);
    @(negedge clk); idle(); set_tag(2, 44'h124); #1;
    chk("miss_rvalid", rvalid, 4'b0100);
    chk("miss_way", hit, 8'h00);

    // Multihit: way 6 gets the same tag
    @(negedge clk); idle(); put(0, 8'h40, 12'h340, 1'b1, mk_line(44'h123, 1'b1));
    @(negedge clk); idle(); put(3, 8'hFF, 12'h340, 1'b0, '0);
    @(negedge clk); idle(); set_tag(3, 44'h123); #1;
    chk("mh_rvalid", rvalid, 4'b1000);
    chk("mh_way", hit, 8'h60);
    chk("mh_flag", multihit, 1'b1);

    // Victim: ways 0..2 valid, way 3 invalid
    @(negedge clk); idle(); put(1, 8'h07, 12'h550, 1'b1, mk_line(44'h77, 1'b1));
    @(negedge clk); idle(); put(1, 8'hFF, 12'h550, 1'b0, '0);
    @(negedge clk); idle(); set_tag(1, 44'h77); #1;
    chk("inv_hit", hit, 8'h07);
    chk("inv_victim", victim, 8'h08);

    // Reset with a read granted in the same cycle drops the response
    @(negedge clk); idle(); put(1, 8'hFF, 12'h550, 1'b0, '0); rst = 1'b1;
    @(negedge clk); idle(); #1;
    chk("rst_drop_rvalid", rvalid, 4'b0000);
    chk("rst_init_done", init_done, 1'b0);

    // Reset mid-sweep at set 100, then full restart
    sb_fill();
    sweep_cycles(100);
    @(negedge clk);
    sweep_cycle();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk); #1;
    chk("midsweep_reset_outputs", {gnt, rvalid, multihit, init_done}, 10'b0);
    @(negedge clk);
    sb_fill();
    sweep_cycles(256);
    sweep_done();

    // All ways valid: victim follows the LFSR from its reset seed
    @(negedge clk); idle(); put(0, 8'hFF, 12'h660, 1'b1, mk_line(44'h9A, 1'b1));
    model = 16'hACE1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk); idle(); set_tag(1, 44'h9A);
      if (i < 8) put(1, 8'hFF, 12'h660, 1'b0, '0);
      #1;
      if (i > 0) begin
        chk($sformatf("lfsr_rvalid[%0d]", i), rvalid, 4'b0010);
        chk($sformatf("lfsr_hit[%0d]", i), hit, 8'hFF);
        chk($sformatf("lfsr_victim[%0d]", i), victim, NW'(1) << model[2:0]);
        chk($sformatf("lfsr_onehot[%0d]", i), $onehot(victim), 1'b1);
        model = lfsr_step(model);
      end
    end

    // Invalidate in the same cycle as a granted read from port 1
    @(negedge clk); idle(); put(2, 8'h04, 12'h770, 1'b1, mk_line(44'h55, 1'b1));
    @(negedge clk); idle(); put(1, 8'hFF, 12'h770, 1'b0, '0); inval = 1'b1; #1;
    chk("inval_gnt", gnt, 4'b0010);
    @(negedge clk); inval = 1'b0; set_tag(1, 44'h55);
    sb_fill();
    sweep_cycle();
    chk("inval_rvalid", rvalid, 4'b0010);
    chk("inval_hit", hit, 8'h04);
    sweep_cycles(255);
    sweep_done();
    chk("inval_regrant", gnt, 4'b0010);
    @(negedge clk); idle(); set_tag(1, 44'h55); #1;
    chk("inval_after_rvalid", rvalid, 4'b0010);
    chk("inval_after_miss", hit, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
